// File: rtl/axi_slave_rd.sv
// axi_slave_rd: AXI4 read-channel responder in front of a synchronous memory
// with a 1-cycle read latency. It accepts one AR burst at a time, issues one
// memory read per beat and returns the data on R through a 2-entry buffer.
// The buffer absorbs the memory latency while the master applies backpressure.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   s_axi_ar*             read address channel (slave side)
//   s_axi_r*              read data channel (slave side)
//   mem_rd_en/addr        memory read strobe and word address
//   mem_rd_data           memory data, valid the cycle after mem_rd_en
//   busy                  high while a burst is being served
module axi_slave_rd #(
  parameter int         AXI_WIDTH  = 64,
  parameter logic [2:0] AXI_AXSIZE = 3'b011,
  parameter int         MEM_AW     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           s_axi_arid,
  input  logic [29:0]          s_axi_araddr,
  input  logic [7:0]           s_axi_arlen,
  input  logic [2:0]           s_axi_arsize,
  input  logic [1:0]           s_axi_arburst,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [3:0]           s_axi_rid,
  output logic [AXI_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rlast,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic                 mem_rd_en,
  output logic [MEM_AW-1:0]    mem_rd_addr,
  input  logic [AXI_WIDTH-1:0] mem_rd_data,
  output logic                 busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RD = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_arready;
  logic [3:0]          r_id;
  logic [7:0]          r_len;
  logic                r_fixed;
  logic                r_slverr;
  logic [MEM_AW-1:0]   r_addr;
  logic [8:0]          r_issue;
  logic                r_inflight;
  logic [7:0]          r_rx;
  logic [AXI_WIDTH-1:0] r_buf_data [2];
  logic                r_buf_last [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_cnt;
  logic                w_ar_hs;
  logic                w_pop;
  logic                w_mem_rd_en;
  logic [2:0]          w_occ;
  logic [29:0]         w_word_full;
  logic                w_unused_addr;

  assign w_ar_hs     = s_axi_arvalid & r_arready;
  assign w_pop       = s_axi_rvalid & s_axi_rready;
  // Word address is derived from the supported beat size, not from arsize.
  assign w_word_full = s_axi_araddr >> AXI_AXSIZE;
  assign w_unused_addr = ^w_word_full[29:MEM_AW];
  // Buffer slots committed after this cycle: stored + in flight - leaving now.
  assign w_occ = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_hs) w_next_state = ST_RD;
        else         w_next_state = ST_IDLE;
      end
      ST_RD: begin
        if (w_pop && s_axi_rlast) w_next_state = ST_IDLE;
        else                      w_next_state = ST_RD;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: memory issue while beats remain and the buffer has room
  always_comb begin
    w_mem_rd_en = 1'b0;
    case (r_state)
      ST_RD: begin
        if ((r_issue <= {1'b0, r_len}) && (w_occ < 3'd2)) w_mem_rd_en = 1'b1;
        else                                              w_mem_rd_en = 1'b0;
      end
      default: w_mem_rd_en = 1'b0;
    endcase
  end

  // arready is registered so it rises one edge after reset release and
  // one edge after a burst completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arready <= 1'b0;
    end else begin
      r_arready <= (w_next_state == ST_IDLE);
    end
  end

  // Burst context capture and per-issue address/issue counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id       <= 4'd0;
      r_len      <= 8'd0;
      r_fixed    <= 1'b0;
      r_slverr   <= 1'b0;
      r_addr     <= '0;
      r_issue    <= 9'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_mem_rd_en;
      if (w_ar_hs) begin
        r_id     <= s_axi_arid;
        r_len    <= s_axi_arlen;
        r_fixed  <= (s_axi_arburst == 2'b00);
        r_slverr <= (s_axi_arsize != AXI_AXSIZE);
        r_addr   <= w_word_full[MEM_AW-1:0];
        r_issue  <= 9'd0;
      end else if (w_mem_rd_en) begin
        r_issue <= r_issue + 9'd1;
        if (!r_fixed) r_addr <= r_addr + MEM_AW'(1);
      end
    end
  end

  // Two-entry output buffer; the in-flight read lands the cycle after issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_last[i] <= 1'b0;
      end
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
      r_rx   <= 8'd0;
    end else begin
      if (w_ar_hs) begin
        r_rx <= 8'd0;
      end else if (r_inflight) begin
        r_rx <= r_rx + 8'd1;
      end
      if (r_inflight) begin
        r_buf_data[r_wptr] <= mem_rd_data;
        r_buf_last[r_wptr] <= (r_rx == r_len);
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({r_inflight, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = (r_cnt != 2'd0);
  assign s_axi_rdata   = r_buf_data[r_rptr];
  // Gate with rvalid so a stale last flag never shows on an empty buffer.
  assign s_axi_rlast   = s_axi_rvalid & r_buf_last[r_rptr];
  assign s_axi_rresp   = r_slverr ? 2'b10 : 2'b00;
  assign s_axi_rid     = r_id;
  assign mem_rd_en     = w_mem_rd_en;
  assign mem_rd_addr   = r_addr;
  assign busy          = (r_state == ST_RD);

endmodule

// File: tb/tb_axi_slave_rd.sv
// Directed testbench for axi_slave_rd with a 1-cycle-latency memory model
// preloaded with mem[k] = k.
module tb_axi_slave_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid = 4'd0;
  logic [29:0] araddr = 30'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd0;
  logic [1:0]  arburst = 2'd0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [63:0] mem_rd_data = 64'd0;
  logic        busy;

  logic [63:0] mem [1024];
  int checks = 0;
  int errors = 0;

  axi_slave_rd #(.AXI_WIDTH(64), .AXI_AXSIZE(3'b011), .MEM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 64'(k);
  end

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the AR handshake.
  task automatic send_ar(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size;
    arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ar_ready_wait", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("busy_after_ar", 64'(busy), 64'd1);
    check("arready_low_in_rd", 64'(arready), 64'd0);
  endtask

  // Steps cycle by cycle, driving rready from a pattern and checking each
  // issue and each beat. abort_at >= 0 asserts rst when that beat is presented.
  task automatic run_burst(input int n, input int start, input bit fixed, input logic [1:0] resp,
                           input logic [3:0] id, input logic [5:0] pat, input int plen,
                           input int abort_at, input bit check_lat);
    int c = 0;
    int issued = 0;
    int taken = 0;
    int first_rv = -1;
    int first_en = -1;
    bit done = 0;
    bit stalled = 0;
    logic [63:0] pd = 64'd0;
    logic pl = 1'b0;
    logic [63:0] ea;
    while (!done && c < 200) begin
      rready = pat[c % plen];
      #1;
      if (abort_at >= 0 && taken == abort_at && rvalid) begin
        rst = 1'b1;
        #1;
        check("abort_rvalid", 64'(rvalid), 64'd0);
        check("abort_rlast", 64'(rlast), 64'd0);
        check("abort_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_arready", 64'(arready), 64'd0);
        check("abort_rdata", rdata, 64'd0);
        rready = 1'b0;
        return;
      end
      if (mem_rd_en) begin
        if (first_en < 0) first_en = c;
        ea = fixed ? 64'(start) : 64'((start + issued) % 1024);
        check("mem_rd_addr", 64'(mem_rd_addr), ea);
        check("no_overissue", 64'((issued - taken - int'(rvalid && rready)) <= 1), 64'd1);
        issued++;
      end
      if (stalled) begin
        check("hold_rvalid", 64'(rvalid), 64'd1);
        check("hold_rdata", rdata, pd);
        check("hold_rlast", 64'(rlast), 64'(pl));
      end
      if (rvalid && first_rv < 0) first_rv = c;
      if (rvalid && rready) begin
        ea = fixed ? 64'(start) : 64'((start + taken) % 1024);
        check("rdata", rdata, ea);
        check("rlast", 64'(rlast), 64'(taken == n - 1));
        check("rresp", 64'(rresp), 64'(resp));
        check("rid", 64'(rid), 64'(id));
        taken++;
        if (taken == n) done = 1;
      end
      stalled = rvalid && !rready;
      pd = rdata;
      pl = rlast;
      @(posedge clk); #1;
      c++;
    end
    rready = 1'b0;
    check("beat_count", 64'(taken), 64'(n));
    check("issue_count", 64'(issued), 64'(n));
    check("rvalid_after_burst", 64'(rvalid), 64'd0);
    if (check_lat) begin
      check("first_mem_rd_en_cycle", 64'(first_en), 64'd0);
      check("first_rvalid_cycle", 64'(first_rv), 64'd2);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    check("arready_before_edge", 64'(arready), 64'd0);
    @(posedge clk); #1;
    check("arready_after_edge", 64'(arready), 64'd1);

    // INCR 4 beats from word 8, rready held high
    send_ar(4'h1, 30'h40, 8'd3, 2'b01, 3'b011);
    run_burst(4, 8, 1'b0, 2'b00, 4'h1, 6'b111111, 1, -1, 1'b1);

    // Same burst with rready pattern 1,0,0,1,0,1
    send_ar(4'h1, 30'h40, 8'd3, 2'b01, 3'b011);
    run_burst(4, 8, 1'b0, 2'b00, 4'h1, 6'b101001, 6, -1, 1'b1);

    // Single beat; idle cycle follows
    send_ar(4'h5, 30'h40, 8'd0, 2'b01, 3'b011);
    run_burst(1, 8, 1'b0, 2'b00, 4'h5, 6'b111111, 1, -1, 1'b1);
    check("len0_busy_fall", 64'(busy), 64'd0);
    check("len0_arready_rise", 64'(arready), 64'd1);

    // FIXED burst at word 3
    send_ar(4'h2, 30'h18, 8'd2, 2'b00, 3'b011);
    run_burst(3, 3, 1'b1, 2'b00, 4'h2, 6'b111111, 1, -1, 1'b1);

    // Unsupported arsize: SLVERR on every beat, data still returned
    send_ar(4'h3, 30'h40, 8'd1, 2'b01, 3'b010);
    run_burst(2, 8, 1'b0, 2'b10, 4'h3, 6'b111111, 1, -1, 1'b1);

    // Address wrap 1023 -> 0
    send_ar(4'h4, 30'h1FF8, 8'd1, 2'b01, 3'b011);
    run_burst(2, 1023, 1'b0, 2'b00, 4'h4, 6'b111111, 1, -1, 1'b1);

    // Reset during beat 2 of 8, then a fresh 2-beat burst
    send_ar(4'h6, 30'h0, 8'd7, 2'b01, 3'b011);
    run_burst(8, 0, 1'b0, 2'b00, 4'h6, 6'b111111, 1, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_abort_arready", 64'(arready), 64'd1);
    send_ar(4'h7, 30'h100, 8'd1, 2'b01, 3'b011);
    run_burst(2, 32, 1'b0, 2'b00, 4'h7, 6'b111111, 1, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
